// File: rtl/e1_led_ctrl.sv
// e1_led_ctrl: decodes per-LED modes (off/on/slow/fast blink) and serialises them onto an external shift/latch chain.
// Latency: led_state is sampled at LOAD; the chain latches it 1+2*DIV*N_LED cycles later; one frame = 1+2*DIV*N_LED+DIV+GAP cycles.
// Backpressure: none; free-running while led_run=1; a stop always finishes the frame, then sends one blank frame.
// Optional feature macro: E1_LED_INVERT_EN (adds INV_MASK for active-low LEDs; blank frame sends INV_MASK).
// Ports: clk, rst_n (async active-low); led_state[2*N_LED-1:0] mode per LED (LED k at [2k+1:2k]);
//        led_run enable; led_active high whenever not IDLE; led_sclk/led_sdata/led_latch drive the chain (MSB = LED N_LED-1 first).
module e1_led_ctrl #(
  parameter int N_LED    = 4,
  parameter int DIV      = 16,
  parameter int GAP      = 256,
  parameter int FAST_BIT = 3,
  parameter int SLOW_BIT = 5
`ifdef E1_LED_INVERT_EN
  ,
  parameter logic [N_LED-1:0] INV_MASK = '0
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2*N_LED-1:0] led_state,
  input  logic               led_run,
  output logic               led_active,
  output logic               led_sclk,
  output logic               led_sdata,
  output logic               led_latch
);

  localparam int PW = 8;
  localparam int GW = 16;
  localparam int BW = (N_LED > 1) ? $clog2(N_LED) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LATCH,
    ST_GAP
  } state_t;

  state_t           state_q;
  state_t           state_nxt;
  logic [PW-1:0]    presc_q;
  logic             presc_wrap;
  logic [GW-1:0]    gap_q;
  logic             gap_done;
  logic [BW-1:0]    bit_q;
  logic [N_LED-1:0] sreg_q;
  logic [N_LED-1:0] sreg_sh;
  logic [N_LED-1:0] dec_bits;
  logic [N_LED-1:0] snap_val;
  logic [N_LED-1:0] blank_val;
  logic [N_LED-1:0] load_val;
  logic [7:0]       fc_q;
  logic             run_q;
  logic             run_fall;
  logic             blank_owed_q;
  logic             blank_pend;
  logic             load_blank_q;

  assign presc_wrap = (presc_q == PW'(DIV - 1));
  assign gap_done   = (gap_q == GW'(GAP - 1));
  assign sreg_sh    = sreg_q << 1;

  // A falling led_run in the same cycle GAP ends must still earn its blank
  // frame, so the fresh edge is folded into the pending flag combinationally.
  assign run_fall   = run_q & ~led_run;
  assign blank_pend = blank_owed_q | (run_fall & (state_q != ST_IDLE));

  // Mode decode against the frame counter phases.
  always_comb begin
    dec_bits = '0;
    for (int k = 0; k < N_LED; k++) begin
      case (led_state[2*k +: 2])
        2'b00:   dec_bits[k] = 1'b0;
        2'b01:   dec_bits[k] = 1'b1;
        2'b10:   dec_bits[k] = fc_q[SLOW_BIT];
        default: dec_bits[k] = fc_q[FAST_BIT];
      endcase
    end
  end

`ifdef E1_LED_INVERT_EN
  assign snap_val  = dec_bits ^ INV_MASK;
  assign blank_val = INV_MASK;
`else
  assign snap_val  = dec_bits;
  assign blank_val = '0;
`endif

  assign load_val = load_blank_q ? blank_val : snap_val;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:     if (led_run) state_nxt = ST_LOAD;
      ST_LOAD:     state_nxt = ST_SHIFT_LO;
      ST_SHIFT_LO: if (presc_wrap) state_nxt = ST_SHIFT_HI;
      ST_SHIFT_HI: if (presc_wrap) state_nxt = (bit_q == '0) ? ST_LATCH : ST_SHIFT_LO;
      ST_LATCH:    if (presc_wrap) state_nxt = ST_GAP;
      ST_GAP:      if (gap_done) state_nxt = (led_run || blank_pend) ? ST_LOAD : ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs. Strobes are decoded from the next state
  // so each output is aligned exactly with the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_sclk     <= 1'b0;
      led_sdata    <= 1'b0;
      led_latch    <= 1'b0;
      led_active   <= 1'b0;
      presc_q      <= '0;
      gap_q        <= '0;
      bit_q        <= '0;
      sreg_q       <= '0;
      fc_q         <= '0;
      run_q        <= 1'b0;
      blank_owed_q <= 1'b0;
      load_blank_q <= 1'b0;
    end else begin
      run_q      <= led_run;
      led_sclk   <= (state_nxt == ST_SHIFT_HI);
      led_latch  <= (state_nxt == ST_LATCH);
      led_active <= (state_nxt != ST_IDLE);

      // Prescaler runs only in the DIV-timed states and restarts at each exit.
      if (state_q inside {ST_SHIFT_LO, ST_SHIFT_HI, ST_LATCH})
        presc_q <= presc_wrap ? '0 : presc_q + 1'b1;
      else
        presc_q <= '0;

      if (state_q == ST_GAP && !gap_done) gap_q <= gap_q + 1'b1;
      else                                gap_q <= '0;

      case (state_q)
        ST_IDLE: load_blank_q <= 1'b0;
        ST_LOAD: begin
          sreg_q    <= load_val;
          bit_q     <= BW'(N_LED - 1);
          led_sdata <= load_val[N_LED-1];
        end
        ST_SHIFT_HI: begin
          if (presc_wrap) begin
            sreg_q <= sreg_sh;
            if (bit_q == '0) begin
              led_sdata <= 1'b0;
            end else begin
              led_sdata <= sreg_sh[N_LED-1];
              bit_q     <= bit_q - 1'b1;
            end
          end
        end
        ST_LATCH: if (presc_wrap) fc_q <= fc_q + 8'd1;
        ST_GAP:   if (gap_done) load_blank_q <= !led_run && blank_pend;
        default: ;
      endcase

      // Blank-frame bookkeeping: a running enable cancels it, the GAP exit
      // consumes it, a stop while busy arms it.
      if (led_run)
        blank_owed_q <= 1'b0;
      else if (state_q == ST_GAP && gap_done)
        blank_owed_q <= 1'b0;
      else if (run_fall && state_q != ST_IDLE)
        blank_owed_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_e1_led_ctrl.sv
// Bench for e1_led_ctrl: table-driven static frames, blink sweep, stop/restart, tearing and reset corner cases.
module tb_e1_led_ctrl;

  localparam int N_LED = 4;
  localparam int DIV   = 16;
  localparam int GAP   = 256;
  localparam int FRAME = 1 + 2*DIV*N_LED + DIV + GAP;
`ifdef E1_LED_INVERT_EN
  localparam logic [3:0] INV = 4'b1010;
`else
  localparam logic [3:0] INV = 4'b0000;
`endif

  localparam int EV_LATCH      = 0;
  localparam int EV_SCLK_RISE  = 1;
  localparam int EV_SCLK_FALL  = 2;
  localparam int EV_LATCH_FALL = 3;
  localparam int EV_ACT_FALL   = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       led_run;
  logic [7:0] led_state;
  logic       led_active, led_sclk, led_sdata, led_latch;

  always #5 clk = ~clk;

`ifdef E1_LED_INVERT_EN
  e1_led_ctrl #(.N_LED(N_LED), .DIV(DIV), .GAP(GAP), .FAST_BIT(3), .SLOW_BIT(5), .INV_MASK(INV)) dut (
    .clk(clk), .rst_n(rst_n), .led_state(led_state), .led_run(led_run),
    .led_active(led_active), .led_sclk(led_sclk), .led_sdata(led_sdata), .led_latch(led_latch));
`else
  e1_led_ctrl #(.N_LED(N_LED), .DIV(DIV), .GAP(GAP), .FAST_BIT(3), .SLOW_BIT(5)) dut (
    .clk(clk), .rst_n(rst_n), .led_state(led_state), .led_run(led_run),
    .led_active(led_active), .led_sclk(led_sclk), .led_sdata(led_sdata), .led_latch(led_latch));
`endif

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Expected frame from led_state and frame number: bit k = LED k, sent MSB first.
  function automatic logic [3:0] model(input logic [7:0] st, input int fc);
    logic [7:0] f;
    logic [3:0] r;
    f = 8'(fc);
    r = '0;
    for (int k = 0; k < 4; k++) begin
      case (st[2*k +: 2])
        2'b00:   r[k] = 1'b0;
        2'b01:   r[k] = 1'b1;
        2'b10:   r[k] = f[5];
        default: r[k] = f[3];
      endcase
    end
    return r ^ INV;
  endfunction

  // Scoreboard: one expected frame per latch pulse.
  logic [3:0] exp_q[$];
  int         next_frame = 0;

  task automatic push_st(input logic [7:0] st);
    exp_q.push_back(model(st, next_frame));
    next_frame++;
  endtask

  task automatic push_blank();
    exp_q.push_back(INV);
    next_frame++;
  endtask

  // Monitor state, written only by the monitor process.
  int         cyc = 0;
  int         t_act_rise = 0, t_act_fall = 0, t_latch_rise = 0, t_latch_fall = 0;
  int         n_latch = 0, n_latch_fall = 0, n_sclk_rise = 0, n_sclk_fall = 0, n_act_fall = 0;
  logic       first_sclk_pend = 1'b0, first_latch_pend = 1'b0, have_prev = 1'b0;
  logic       p_act = 1'b0, p_sclk = 1'b0, p_latch = 1'b0;
  logic [3:0] bits = '0;
  logic [3:0] e;

  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (led_active && !p_act) begin
        t_act_rise = cyc;
        first_sclk_pend = 1'b1;
        first_latch_pend = 1'b1;
        bits = '0;
      end
      if (!led_active && p_act) begin
        t_act_fall = cyc;
        n_act_fall++;
        have_prev = 1'b0;
      end
      if (led_sclk && !p_sclk) begin
        bits = {bits[2:0], led_sdata};
        n_sclk_rise++;
        if (first_sclk_pend) begin
          chk("first_sclk_delay", cyc - t_act_rise, 1 + DIV);
          first_sclk_pend = 1'b0;
        end
      end
      if (!led_sclk && p_sclk) n_sclk_fall++;
      if (led_latch && !p_latch) begin
        n_latch++;
        chk("latch_sdata", int'(led_sdata), 0);
        if (first_latch_pend) begin
          chk("first_latch_delay", cyc - t_act_rise, 1 + 2*DIV*N_LED);
          first_latch_pend = 1'b0;
        end
        if (have_prev) chk("frame_period", cyc - t_latch_rise, FRAME);
        have_prev = 1'b1;
        t_latch_rise = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL frame%0d: got 0x%0h, expected no frame", n_latch, bits);
        end else begin
          e = exp_q.pop_front();
          if (bits != e) begin
            errors++;
            $display("FAIL frame%0d: got 0x%0h, expected 0x%0h", n_latch, bits, e);
          end
        end
      end
      if (!led_latch && p_latch) begin
        t_latch_fall = cyc;
        n_latch_fall++;
        chk("latch_width", cyc - t_latch_rise, DIV);
      end
      p_act = led_active;
      p_sclk = led_sclk;
      p_latch = led_latch;
    end
  end

  function automatic int ev_cnt(input int sel);
    case (sel)
      EV_LATCH:      return n_latch;
      EV_SCLK_RISE:  return n_sclk_rise;
      EV_SCLK_FALL:  return n_sclk_fall;
      EV_LATCH_FALL: return n_latch_fall;
      default:       return n_act_fall;
    endcase
  endfunction

  // Bounded wait for n more monitor events; an expired budget is a failure.
  task automatic wait_ev(input int sel, input int n, input string what);
    int target;
    int budget;
    target = ev_cnt(sel) + n;
    budget = (n + 2) * FRAME;
    while (ev_cnt(sel) < target && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    checks++;
    if (ev_cnt(sel) < target) begin
      errors++;
      $display("FAIL %s: timeout, saw %0d events, required %0d", what, ev_cnt(sel) - target + n, n);
    end
  endtask

  typedef struct {
    logic [7:0] st;
    logic [3:0] exp;
    string      name;
  } vec_t;

  vec_t tab[5];

  initial begin : driver
    int saved;
    tab[0] = '{8'b01_01_01_01, 4'b1111, "all_on"};
    tab[1] = '{8'b00_00_00_00, 4'b0000, "all_off"};
    tab[2] = '{8'b01_00_00_01, 4'b1001, "ends_on"};
    tab[3] = '{8'b00_01_00_01, 4'b0101, "alt_lo"};
    tab[4] = '{8'b01_00_01_00, 4'b1010, "alt_hi"};

    // Reset held with led_run=1: every output stays low.
    rst_n = 1'b1;
    led_run = 1'b1;
    led_state = 8'b00_01_01_00;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sclk",   int'(led_sclk),   0);
    chk("rst_sdata",  int'(led_sdata),  0);
    chk("rst_latch",  int'(led_latch),  0);
    chk("rst_active", int'(led_active), 0);

    // Static pattern 0110 for three frames.
    repeat (3) push_st(led_state);
    rst_n = 1'b1;
    wait_ev(EV_LATCH, 3, "static");

    // Table of constant patterns, one frame each.
    for (int i = 0; i < 5; i++) begin
      led_state = tab[i].st;
      exp_q.push_back(tab[i].exp ^ INV);
      next_frame++;
      wait_ev(EV_LATCH, 1, tab[i].name);
    end

    // Blink sweep: LED3 slow, LED2 fast, over 64 frames.
    led_state = 8'b10_11_00_00;
    repeat (64) push_st(led_state);
    wait_ev(EV_LATCH, 64, "blink");

    // Tearing: change led_state mid-frame; visible only in the next frame.
    led_state = 8'b00_00_01_01;
    push_st(led_state);
    wait_ev(EV_SCLK_RISE, 2, "tear_mid");
    led_state = 8'b01_01_00_00;
    push_st(led_state);
    wait_ev(EV_LATCH, 2, "tear");

    // Stop during the second bit: frame finishes, one blank frame, then IDLE.
    push_st(led_state);
    wait_ev(EV_SCLK_FALL, 1, "stop_bit1");
    led_run = 1'b0;
    push_blank();
    wait_ev(EV_LATCH, 2, "stop_frames");
    wait_ev(EV_ACT_FALL, 1, "stop_idle");
    chk("idle_delay", t_act_fall - t_latch_fall, GAP);
    saved = n_latch;
    repeat (FRAME + 50) @(negedge clk);
    chk("idle_no_frames", n_latch, saved);
    chk("idle_active", int'(led_active), 0);
    chk("idle_queue", exp_q.size(), 0);

    // Restart from IDLE, then cancel a stop by re-enabling during GAP.
    led_state = 8'b01_00_00_01;
    led_run = 1'b1;
    push_st(led_state);
    wait_ev(EV_LATCH, 1, "restart");
    push_st(led_state);
    wait_ev(EV_SCLK_FALL, 1, "cancel_bit1");
    led_run = 1'b0;
    wait_ev(EV_LATCH, 1, "cancel_frame");
    wait_ev(EV_LATCH_FALL, 1, "cancel_gap");
    led_run = 1'b1;
    push_st(led_state);
    wait_ev(EV_LATCH, 1, "cancel_next");
    push_st(led_state);
    wait_ev(EV_LATCH, 1, "cancel_cont");
    chk("cancel_active", int'(led_active), 1);

    // Reset mid-frame while led_sclk is high: outputs clear at once.
    wait_ev(EV_SCLK_RISE, 1, "rst_mid_wait");
    rst_n = 1'b0;
    #1;
    chk("midrst_sclk",   int'(led_sclk),   0);
    chk("midrst_sdata",  int'(led_sdata),  0);
    chk("midrst_latch",  int'(led_latch),  0);
    chk("midrst_active", int'(led_active), 0);
    @(negedge clk);
    led_run = 1'b0;
    rst_n = 1'b1;
    saved = n_latch;
    repeat (FRAME) @(negedge clk);
    chk("post_rst_frames", n_latch, saved);
    chk("post_rst_active", int'(led_active), 0);
    chk("final_queue", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/e1_led_ctrl.md
Name: e1_led_ctrl

Overview:
- Downstream consumer of the misc block's E1 LED status (`e1_led_state`, `e1_led_run`); returns `e1_led_active` to it.
- Decodes a 2-bit mode per LED (off, on, slow blink, fast blink).
- Serialises the resulting LED bits into an external shift-register/latch chain using a clock, data and latch strobe.
- Runs autonomously in the system clock domain, free-running frame after frame while enabled.

Parameters:
- N_LED, 4: number of LEDs in the chain; `led_state` width is 2*N_LED.
- DIV, 16: clk cycles per `led_sclk` half-period; legal range 2..255.
- GAP, 256: idle clk cycles after each latch pulse before the next frame; legal range 1..65535.
- FAST_BIT, 3: frame-counter bit used as the fast blink phase.
- SLOW_BIT, 5: frame-counter bit used as the slow blink phase; must be greater than FAST_BIT and at most 7.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: reset.
- led_state, in, 2*N_LED: per-LED mode; LED k uses bits [2k+1:2k].
- led_run, in, 1: enable scanning.
- led_active, out, 1: high while the engine is not in IDLE.
- led_sclk, out, 1: shift clock to the external chain.
- led_sdata, out, 1: serial data to the external chain.
- led_latch, out, 1: latch strobe to the external chain.

Behaviour:
- Interface: one clock, `clk`; reset `rst_n` is asynchronous and active-low. All outputs are registered.
- Reset values: `led_sclk`=0, `led_sdata`=0, `led_latch`=0, `led_active`=0; FSM in IDLE; frame counter=0; prescaler=0.
- Prescaler: counts 0..DIV-1 and produces a strobe on wrap. It is held at 0 in IDLE.
- Mode decode per LED k, where `fc` is the 8-bit frame counter:
  - 00 → 0.
  - 01 → 1.
  - 10 → `fc[SLOW_BIT]`.
  - 11 → `fc[FAST_BIT]`.
- Snapshot: decoded bits are captured into an N_LED-bit shift register in LOAD. Changes to `led_state` mid-frame take effect only at the next LOAD, so frames never tear.
- FSM states:
  - IDLE → LOAD when `led_run`=1.
  - LOAD, 1 cycle: capture snapshot, load bit counter with N_LED-1, set `led_sdata` to the MSB (LED N_LED-1) → SHIFT_LO.
  - SHIFT_LO: `led_sclk`=0 for DIV cycles → SHIFT_HI.
  - SHIFT_HI: `led_sclk`=1 for DIV cycles. On exit, shift left and present the next bit on `led_sdata`.
    - If the bit counter is 0 → LATCH.
    - Otherwise decrement the bit counter → SHIFT_LO.
  - LATCH: `led_latch`=1 and `led_sdata`=0 for DIV cycles; the frame counter increments with 8-bit wrap → GAP.
  - GAP: all strobes low for GAP cycles.
    - If `led_run`=1 → LOAD.
    - Else if a blank frame is still owed → LOAD with the snapshot forced to all-zero.
    - Otherwise → IDLE.
- Stop rule:
  - Deassertion of `led_run` never aborts a frame.
  - It arms a blank-frame flag. Exactly one all-off frame is sent after the current frame, then the FSM enters IDLE.
  - Reasserting `led_run` before the blank frame's LOAD cancels the blank frame.
- Frame length: 1 + 2·DIV·N_LED + DIV + GAP cycles; with defaults this is 401.
- `led_active` is high in every state except IDLE. It drops in the cycle after GAP exits to IDLE.
- Reset mid-frame: all outputs go to their reset values immediately. The external latch keeps its previous contents.

Optional Feature:
- Macro: E1_LED_INVERT_EN.
- With the macro defined:
  - Add parameter INV_MASK (default 0, N_LED bits).
  - Decoded bit k is XORed with INV_MASK[k] before snapshot, supporting active-low LEDs.
  - The blank frame sends INV_MASK itself, so LEDs are physically off.
- Without the macro: no parameter, no XOR; the blank frame is all zero.

Test Plan:
- Reset behaviour: assert `rst_n`=0 with `led_run`=1, release → all outputs 0 during reset; first `led_sclk` rise 1+DIV cycles after the first LOAD.
- Static pattern: `led_state`=8'b00_01_01_00, `led_run`=1, defaults → bits 0,1,1,0 sampled on four `led_sclk` rises, MSB first; `led_latch` high 16 cycles; next LOAD 401 cycles after the first.
- Blink: `led_state`=8'b10_11_00_00 → LED3 toggles every 32 frames and LED2 every 8 frames, checked over 64 frames.
- Stop mid-frame: drop `led_run` during the second bit → current frame completes, one frame of 0000 follows, then IDLE; `led_active` falls 1 cycle after that frame's GAP ends.
- Restart and tearing: reassert `led_run` during the first GAP after the stop → no blank frame, scanning continues. Change `led_state` mid-frame → the change appears only in the following frame.
- Invert feature: with E1_LED_INVERT_EN and INV_MASK=4'b1010, `led_state`=0 → frame 1010; the blank frame after stop is also 1010.
